// File: rtl/lcdg_bus_ctrl_if.sv
// Request handshake plus LCD pad-side bus for the graphic LCD sequencer.
// The master modport is the graphics engine; the slave modport is lcdg_bus_ctrl.
interface lcdg_bus_ctrl_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_dori;
    logic [1:0] req_cs;
    logic [7:0] req_data;
    logic       init_done;
    logic       busy;
    logic [7:0] db_o;
    logic       dori_o;
    logic       rw_o;
    logic       en_o;
    logic       cs1_o;
    logic       cs2_o;
    logic       rst_o;

    modport master (
        output req_valid, req_dori, req_cs, req_data,
        input  req_ready, init_done, busy,
        input  db_o, dori_o, rw_o, en_o, cs1_o, cs2_o, rst_o
    );

    modport slave (
        input  req_valid, req_dori, req_cs, req_data,
        output req_ready, init_done, busy,
        output db_o, dori_o, rw_o, en_o, cs1_o, cs2_o, rst_o
    );
endinterface

// File: rtl/lcdg_bus_ctrl.sv
// Write-only sequencer for a dual-controller (CS1/CS2) graphic LCD: power-up, then timed byte writes.
// Define LCDG_CLEAR_ON_INIT_EN to blank all 8 pages x 64 columns after the init commands.
module lcdg_bus_ctrl #(
    parameter int SETUP_CYC = 4,
    parameter int EN_HI_CYC = 25,
    parameter int HOLD_CYC  = 25,
    parameter int RST_CYC   = 50
) (
    input  logic           clk,
    input  logic           rstn,
    lcdg_bus_ctrl_if.slave bus
);

    localparam logic [15:0] SETUP_LD = 16'(SETUP_CYC - 1);
    localparam logic [15:0] EN_LD    = 16'(EN_HI_CYC - 1);
    localparam logic [15:0] HOLD_LD  = 16'(HOLD_CYC - 1);
    localparam logic [15:0] RST_LD   = 16'(RST_CYC - 1);

    typedef enum logic [2:0] {
        S_RST_LO,
        S_RST_WAIT,
        S_INIT,
        S_IDLE,
        S_SETUP,
        S_EN_HI,
        S_HOLD
`ifdef LCDG_CLEAR_ON_INIT_EN
        , S_CLEAR
`endif
    } state_t;

    state_t      state_q;
    state_t      ret_q;       // where HOLD returns once the current write completes
    logic [15:0] cnt_q;
    logic [1:0]  init_step_q;
    logic [7:0]  db_q;
    logic        dori_q;
    logic        cs1_q;
    logic        cs2_q;
    logic        en_q;
    logic        rst_q;
    logic        ready_q;
    logic        done_q;
    logic        busy_q;
`ifdef LCDG_CLEAR_ON_INIT_EN
    logic [2:0]  page_q;
    logic [6:0]  col_q;
    logic [1:0]  clr_phase_q;
    logic        clr_last_q;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_RST_LO;
            ret_q       <= S_IDLE;
            cnt_q       <= RST_LD;
            init_step_q <= 2'd0;
            db_q        <= 8'h00;
            dori_q      <= 1'b0;
            cs1_q       <= 1'b0;
            cs2_q       <= 1'b0;
            en_q        <= 1'b0;
            rst_q       <= 1'b0;
            ready_q     <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b1;
`ifdef LCDG_CLEAR_ON_INIT_EN
            page_q      <= 3'd0;
            col_q       <= 7'd0;
            clr_phase_q <= 2'd0;
            clr_last_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_RST_LO: begin
                    if (cnt_q == 16'd0) begin
                        rst_q   <= 1'b1;
                        cnt_q   <= RST_LD;
                        state_q <= S_RST_WAIT;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                S_RST_WAIT: begin
                    if (cnt_q == 16'd0) begin
                        init_step_q <= 2'd0;
                        state_q     <= S_INIT;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                S_INIT: begin
                    // One dispatch cycle per init command; step 2 means both are done.
                    if (init_step_q != 2'd2) begin
                        db_q        <= (init_step_q == 2'd0) ? 8'h3F : 8'hC0;
                        dori_q      <= 1'b0;
                        cs1_q       <= 1'b1;
                        cs2_q       <= 1'b1;
                        cnt_q       <= SETUP_LD;
                        ret_q       <= S_INIT;
                        state_q     <= S_SETUP;
                        init_step_q <= init_step_q + 2'd1;
                    end else begin
`ifdef LCDG_CLEAR_ON_INIT_EN
                        page_q      <= 3'd0;
                        col_q       <= 7'd0;
                        clr_phase_q <= 2'd0;
                        clr_last_q  <= 1'b0;
                        state_q     <= S_CLEAR;
`else
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
`endif
                    end
                end
                S_IDLE: begin
                    // A request with no chip selected is consumed without touching the bus.
                    if (bus.req_valid && ready_q && (bus.req_cs != 2'b00)) begin
                        db_q    <= bus.req_data;
                        dori_q  <= bus.req_dori;
                        cs1_q   <= bus.req_cs[0];
                        cs2_q   <= bus.req_cs[1];
                        cnt_q   <= SETUP_LD;
                        ret_q   <= S_IDLE;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (cnt_q == 16'd0) begin
                        en_q    <= 1'b1;
                        cnt_q   <= EN_LD;
                        state_q <= S_EN_HI;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                S_EN_HI: begin
                    if (cnt_q == 16'd0) begin
                        en_q    <= 1'b0;
                        cnt_q   <= HOLD_LD;
                        state_q <= S_HOLD;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                S_HOLD: begin
                    if (cnt_q == 16'd0) begin
                        cs1_q   <= 1'b0;
                        cs2_q   <= 1'b0;
                        state_q <= ret_q;
                        if (ret_q == S_IDLE) begin
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
`ifdef LCDG_CLEAR_ON_INIT_EN
                S_CLEAR: begin
                    if (clr_last_q) begin
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        case (clr_phase_q)
                            2'd0: begin
                                db_q        <= 8'hB8 | {5'd0, page_q};
                                dori_q      <= 1'b0;
                                clr_phase_q <= 2'd1;
                            end
                            2'd1: begin
                                db_q        <= 8'h40;
                                dori_q      <= 1'b0;
                                clr_phase_q <= 2'd2;
                            end
                            default: begin
                                db_q   <= 8'h00;
                                dori_q <= 1'b1;
                                if (col_q == 7'd63) begin
                                    col_q       <= 7'd0;
                                    clr_phase_q <= 2'd0;
                                    page_q      <= page_q + 3'd1;
                                    clr_last_q  <= (page_q == 3'd7);
                                end else begin
                                    col_q <= col_q + 7'd1;
                                end
                            end
                        endcase
                        cs1_q   <= 1'b1;
                        cs2_q   <= 1'b1;
                        cnt_q   <= SETUP_LD;
                        ret_q   <= S_CLEAR;
                        state_q <= S_SETUP;
                    end
                end
`endif
                default: state_q <= S_RST_LO;
            endcase
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.init_done = done_q;
    assign bus.busy      = busy_q;
    assign bus.db_o      = db_q;
    assign bus.dori_o    = dori_q;
    assign bus.rw_o      = 1'b0;
    assign bus.en_o      = en_q;
    assign bus.cs1_o     = cs1_q;
    assign bus.cs2_o     = cs2_q;
    assign bus.rst_o     = rst_q;

endmodule

// File: tb/tb_lcdg_bus_ctrl.sv
// Self-checking bench for lcdg_bus_ctrl: scoreboard of expected LCD writes checked on each en_o rise.
// Build with +define+LCDG_CLEAR_ON_INIT_EN to exercise the panel-clear sequence.
module tb_lcdg_bus_ctrl;

    localparam int SETUP_CYC = 2;
    localparam int EN_HI_CYC = 3;
    localparam int HOLD_CYC  = 2;
    localparam int RST_CYC   = 5;
`ifdef LCDG_CLEAR_ON_INIT_EN
    localparam int INIT_WRITES = 530;
    localparam int INIT_BUDGET = 20000;
`else
    localparam int INIT_WRITES = 2;
    localparam int INIT_BUDGET = 200;
`endif

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    lcdg_bus_ctrl_if bus_if ();

    lcdg_bus_ctrl #(
        .SETUP_CYC(SETUP_CYC),
        .EN_HI_CYC(EN_HI_CYC),
        .HOLD_CYC (HOLD_CYC),
        .RST_CYC  (RST_CYC)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus_if)
    );

    int compared   = 0;
    int mismatched = 0;
    int en_pulses  = 0;

    // Scoreboard entry: {dori, cs1, cs2, db}
    logic [10:0] sb[$];

    logic        en_prev = 1'b0;
    int          en_len  = 0;
    logic [10:0] mon_exp;
    logic [10:0] mon_got;

    always @(negedge clk) begin
        if (!rstn) begin
            en_prev = 1'b0;
            en_len  = 0;
        end else begin
            compared++;
            if (bus_if.rw_o !== 1'b0) begin
                mismatched++;
                $display("FAIL rw_low: rw_o=%b required 0 at %0t", bus_if.rw_o, $time);
            end
            compared++;
            if (bus_if.req_ready && bus_if.busy) begin
                mismatched++;
                $display("FAIL ready_while_busy: req_ready=1 busy=1 at %0t", $time);
            end
            if (bus_if.en_o && !en_prev) begin
                compared++;
                mon_got = {bus_if.dori_o, bus_if.cs1_o, bus_if.cs2_o, bus_if.db_o};
                if (sb.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_write: got %h, none expected at %0t", mon_got, $time);
                end else begin
                    mon_exp = sb.pop_front();
                    if (mon_got !== mon_exp) begin
                        mismatched++;
                        $display("FAIL bus_write: got {dori,cs1,cs2,db}=%h required %h at %0t",
                                 mon_got, mon_exp, $time);
                    end else begin
                        $display("write ok: dori=%b cs1=%b cs2=%b db=%h at %0t",
                                 mon_got[10], mon_got[9], mon_got[8], mon_got[7:0], $time);
                    end
                end
            end
            if (bus_if.en_o) begin
                en_len++;
            end else if (en_prev) begin
                en_pulses++;
                compared++;
                if (en_len != EN_HI_CYC) begin
                    mismatched++;
                    $display("FAIL en_width: en high %0d cycles required %0d", en_len, EN_HI_CYC);
                end
                en_len = 0;
            end
            en_prev = bus_if.en_o;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_init_expect();
        sb.push_back({1'b0, 1'b1, 1'b1, 8'h3F});
        sb.push_back({1'b0, 1'b1, 1'b1, 8'hC0});
`ifdef LCDG_CLEAR_ON_INIT_EN
        for (int p = 0; p < 8; p++) begin
            sb.push_back({1'b0, 1'b1, 1'b1, 8'hB8 | 8'(p)});
            sb.push_back({1'b0, 1'b1, 1'b1, 8'h40});
            for (int c = 0; c < 64; c++) sb.push_back({1'b1, 1'b1, 1'b1, 8'h00});
        end
`endif
    endtask

    task automatic test_reset();
        int lo;
        int gap;
        int cyc;
        int base;
        bus_if.req_valid = 1'b0;
        bus_if.req_dori  = 1'b0;
        bus_if.req_cs    = 2'b00;
        bus_if.req_data  = 8'h00;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        compared++;
        if ({bus_if.db_o, bus_if.dori_o, bus_if.rw_o, bus_if.en_o, bus_if.cs1_o, bus_if.cs2_o,
             bus_if.rst_o, bus_if.req_ready, bus_if.init_done, bus_if.busy} !== 17'b0_0000_0000_0000_0001) begin
            mismatched++;
            $display("FAIL reset_values: db=%h dori=%b rw=%b en=%b cs1=%b cs2=%b rst=%b rdy=%b done=%b busy=%b",
                     bus_if.db_o, bus_if.dori_o, bus_if.rw_o, bus_if.en_o, bus_if.cs1_o, bus_if.cs2_o,
                     bus_if.rst_o, bus_if.req_ready, bus_if.init_done, bus_if.busy);
        end
        push_init_expect();
        base = en_pulses;
        rstn = 1'b1;
        // rst_o is seen low by RST_CYC clock edges after release
        lo = 0;
        while (bus_if.rst_o == 1'b0 && lo < 100) begin
            lo++;
            @(negedge clk);
        end
        compared++;
        if (lo != RST_CYC) begin
            mismatched++;
            $display("FAIL rst_low_len: %0d cycles required %0d", lo, RST_CYC);
        end
        // RST_CYC wait cycles plus the one INIT dispatch cycle before the first SETUP
        gap = 0;
        while (bus_if.cs1_o == 1'b0 && gap < 100) begin
            gap++;
            @(negedge clk);
        end
        compared++;
        if (gap != RST_CYC + 1) begin
            mismatched++;
            $display("FAIL rst_wait_len: %0d cycles to first write required %0d", gap, RST_CYC + 1);
        end
        cyc = 0;
        while (!bus_if.init_done && cyc < INIT_BUDGET) begin
            cyc++;
            @(negedge clk);
        end
        compared++;
        if (!bus_if.init_done) begin
            mismatched++;
            $display("FAIL init_timeout: init_done=0 required 1 after %0d cycles", cyc);
        end
        compared++;
        if (en_pulses - base != INIT_WRITES || sb.size() != 0) begin
            mismatched++;
            $display("FAIL init_writes: %0d pulses (%0d left) required %0d",
                     en_pulses - base, sb.size(), INIT_WRITES);
        end
        compared++;
        if ({bus_if.req_ready, bus_if.busy, bus_if.cs1_o, bus_if.cs2_o} !== 4'b1000) begin
            mismatched++;
            $display("FAIL idle_after_init: rdy=%b busy=%b cs1=%b cs2=%b required 1000",
                     bus_if.req_ready, bus_if.busy, bus_if.cs1_o, bus_if.cs2_o);
        end
        $display("reset test: rst low %0d, gap %0d, init writes %0d", lo, gap, en_pulses - base);
    endtask

    task automatic test_single();
        int first_en;
        int first_rdy;
        @(negedge clk);
        bus_if.req_valid = 1'b1;
        bus_if.req_dori  = 1'b1;
        bus_if.req_cs    = 2'b01;
        bus_if.req_data  = 8'hA5;
        compared++;
        if (bus_if.req_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL single_ready: req_ready=%b required 1", bus_if.req_ready);
        end
        sb.push_back({1'b1, 1'b1, 1'b0, 8'hA5});
        @(posedge clk);
        #1;
        bus_if.req_valid = 1'b0;
        compared++;
        if ({bus_if.req_ready, bus_if.en_o, bus_if.cs1_o, bus_if.cs2_o, bus_if.db_o} !== {4'b0010, 8'hA5}) begin
            mismatched++;
            $display("FAIL single_setup: rdy=%b en=%b cs1=%b cs2=%b db=%h required 0 0 1 0 a5",
                     bus_if.req_ready, bus_if.en_o, bus_if.cs1_o, bus_if.cs2_o, bus_if.db_o);
        end
        first_en  = -1;
        first_rdy = -1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (bus_if.en_o && first_en < 0) first_en = k;
            if (bus_if.req_ready && first_rdy < 0) begin
                first_rdy = k;
                compared++;
                if ({bus_if.cs1_o, bus_if.cs2_o, bus_if.db_o, bus_if.dori_o} !== {2'b00, 8'hA5, 1'b1}) begin
                    mismatched++;
                    $display("FAIL single_idle_bus: cs1=%b cs2=%b db=%h dori=%b required 0 0 a5 1",
                             bus_if.cs1_o, bus_if.cs2_o, bus_if.db_o, bus_if.dori_o);
                end
            end
        end
        compared++;
        if (first_en != SETUP_CYC) begin
            mismatched++;
            $display("FAIL single_en_start: en rose %0d cycles after SETUP entry required %0d", first_en, SETUP_CYC);
        end
        compared++;
        if (first_rdy != SETUP_CYC + EN_HI_CYC + HOLD_CYC) begin
            mismatched++;
            $display("FAIL single_length: idle after %0d cycles required %0d",
                     first_rdy, SETUP_CYC + EN_HI_CYC + HOLD_CYC);
        end
        $display("single write: en at %0d, idle at %0d", first_en, first_rdy);
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes[3];
        logic       acc;
        int         i;
        int         cyc;
        int         base;
        bytes[0] = 8'h12;
        bytes[1] = 8'hE7;
        bytes[2] = 8'h5C;
        base = en_pulses;
        i = 0;
        cyc = 0;
        while (i < 3 && cyc < 200) begin
            @(negedge clk);
            bus_if.req_valid = 1'b1;
            bus_if.req_dori  = i[0];
            bus_if.req_cs    = 2'b11;
            bus_if.req_data  = bytes[i];
            acc = bus_if.req_ready;
            if (acc) sb.push_back({i[0], 1'b1, 1'b1, bytes[i]});
            @(posedge clk);
            if (acc) i++;
            cyc++;
        end
        @(negedge clk);
        bus_if.req_valid = 1'b0;
        compared++;
        if (i != 3) begin
            mismatched++;
            $display("FAIL b2b_accept: %0d accepted required 3", i);
        end
        cyc = 0;
        while (!(bus_if.req_ready && sb.size() == 0) && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        compared++;
        if (en_pulses - base != 3) begin
            mismatched++;
            $display("FAIL b2b_pulses: %0d en pulses required 3", en_pulses - base);
        end
        $display("back-to-back: %0d accepted, %0d pulses", i, en_pulses - base);
    endtask

    task automatic test_cs_none();
        int base;
        base = en_pulses;
        @(negedge clk);
        bus_if.req_valid = 1'b1;
        bus_if.req_dori  = 1'b0;
        bus_if.req_cs    = 2'b00;
        bus_if.req_data  = 8'h99;
        @(posedge clk);
        #1;
        bus_if.req_valid = 1'b0;
        compared++;
        if ({bus_if.req_ready, bus_if.busy, bus_if.en_o, bus_if.cs1_o, bus_if.cs2_o} !== 5'b10000) begin
            mismatched++;
            $display("FAIL cs_none_state: rdy=%b busy=%b en=%b cs1=%b cs2=%b required 10000",
                     bus_if.req_ready, bus_if.busy, bus_if.en_o, bus_if.cs1_o, bus_if.cs2_o);
        end
        repeat (10) @(negedge clk);
        compared++;
        if (en_pulses != base || bus_if.en_o !== 1'b0) begin
            mismatched++;
            $display("FAIL cs_none_pulse: %0d pulses required 0", en_pulses - base);
        end
        $display("cs=00 request consumed, pulses %0d", en_pulses - base);
    endtask

    task automatic test_reset_mid();
        int cyc;
        int lo;
        int base;
        @(negedge clk);
        bus_if.req_valid = 1'b1;
        bus_if.req_dori  = 1'b1;
        bus_if.req_cs    = 2'b10;
        bus_if.req_data  = 8'h3C;
        sb.push_back({1'b1, 1'b0, 1'b1, 8'h3C});
        @(posedge clk);
        #1;
        bus_if.req_valid = 1'b0;
        cyc = 0;
        while (!bus_if.en_o && cyc < 50) begin
            cyc++;
            @(posedge clk);
            #1;
        end
        compared++;
        if (!bus_if.en_o) begin
            mismatched++;
            $display("FAIL mid_en_seen: en_o=0 required 1");
        end
        #2;
        rstn = 1'b0;
        #1;
        compared++;
        if ({bus_if.en_o, bus_if.rst_o, bus_if.cs1_o, bus_if.cs2_o, bus_if.busy, bus_if.init_done} !== 6'b000010) begin
            mismatched++;
            $display("FAIL mid_async_reset: en=%b rst=%b cs1=%b cs2=%b busy=%b done=%b required 000010",
                     bus_if.en_o, bus_if.rst_o, bus_if.cs1_o, bus_if.cs2_o, bus_if.busy, bus_if.init_done);
        end
        sb.delete();
        repeat (2) @(negedge clk);
        push_init_expect();
        base = en_pulses;
        rstn = 1'b1;
        lo = 0;
        while (bus_if.rst_o == 1'b0 && lo < 100) begin
            lo++;
            @(negedge clk);
        end
        compared++;
        if (lo != RST_CYC) begin
            mismatched++;
            $display("FAIL mid_rst_low_len: %0d cycles required %0d", lo, RST_CYC);
        end
        cyc = 0;
        while (!bus_if.init_done && cyc < INIT_BUDGET) begin
            cyc++;
            @(negedge clk);
        end
        compared++;
        if (!bus_if.init_done || en_pulses - base != INIT_WRITES || sb.size() != 0) begin
            mismatched++;
            $display("FAIL mid_reinit: done=%b pulses %0d required %0d", bus_if.init_done,
                     en_pulses - base, INIT_WRITES);
        end
        $display("reset during EN_HI: restart rst low %0d, init writes %0d", lo, en_pulses - base);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_cs_none();
        test_reset_mid();
        test_single();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
